// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO unit: ctl function codes, FSM encoding and watchdog sizing.
package hilo_pkg;

    localparam logic [5:0] MULTU = 6'd25;
    localparam logic [5:0] MFHI  = 6'd16;
    localparam logic [5:0] MTHI  = 6'd17;
    localparam logic [5:0] MFLO  = 6'd18;
    localparam logic [5:0] MTLO  = 6'd19;

    // Must exceed the multiplier latency (32 iterations plus handshake overhead).
    localparam int TIMEOUT = 40;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Codes that touch HI/LO or the multiplier and therefore interlock while BUSY.
    function automatic logic is_hilo_op(input logic [5:0] code);
        return (code == MULTU) || (code == MFHI) || (code == MTHI) ||
               (code == MFLO)  || (code == MTLO);
    endfunction

endpackage

// File: rtl/hilo_watchdog.sv
// Loadable up-counter that saturates at its terminal count; clear has priority over load and enable.
module hilo_watchdog
    import hilo_pkg::*;
#(
    parameter int               W  = CNT_W,
    parameter logic [W-1:0]     TC = W'(TIMEOUT - 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count;

    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != TC)) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == TC);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO architectural registers with multiply issue, MFHI/MFLO/MTHI/MTLO service and BUSY interlock.
module hilo_unit
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  ctl,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [31:0] wr_data,
    output logic        mul_start,
    input  logic        prod_valid,
    input  logic [63:0] prod,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        err
);

    state_t state;
    logic   accept;
    logic   wd_clr;
    logic   wd_en;
    logic   wd_tc;

    // While BUSY only codes that cannot observe HI/LO slip through (and are dropped).
    assign issue_ready = (state == IDLE) || !is_hilo_op(ctl);
    assign accept      = issue_valid && issue_ready;
    assign busy        = (state == BUSY);

    assign wd_clr = accept && (state == IDLE) && (ctl == MULTU);
    assign wd_en  = (state == BUSY) && !prod_valid;

    hilo_watchdog u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr      (wd_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (wd_en),
        .tc       (wd_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hi        <= '0;
            lo        <= '0;
            rd_data   <= '0;
            mul_start <= 1'b0;
            rd_valid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            rd_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (ctl)
                            MULTU: begin
                                mul_start <= 1'b1;
                                state     <= BUSY;
                            end
                            MFHI: begin
                                rd_data  <= hi;
                                rd_valid <= 1'b1;
                            end
                            MFLO: begin
                                rd_data  <= lo;
                                rd_valid <= 1'b1;
                            end
                            MTHI:    hi <= wr_data;
                            MTLO:    lo <= wr_data;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    // A product arriving on the terminal cycle still wins over the abort.
                    if (prod_valid) begin
                        hi    <= prod[63:32];
                        lo    <= prod[31:0];
                        state <= IDLE;
                    end else if (wd_tc) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit: capture, interlock, HI/LO moves, watchdog and reset.
module tb_hilo_unit;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  ctl;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] wr_data;
    logic        mul_start;
    logic        prod_valid;
    logic [63:0] prod;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    hilo_unit dut (
        .clk         (clk),
        .rst         (rst),
        .ctl         (ctl),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .wr_data     (wr_data),
        .mul_start   (mul_start),
        .prod_valid  (prod_valid),
        .prod        (prod),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one edge; inputs driven after this are sampled on the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic ok;

    initial begin
        rst = 1'b1; ctl = '0; issue_valid = 1'b0; wr_data = '0; prod_valid = 1'b0; prod = '0;
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_hi",        hi,          0);
        check("rst_lo",        lo,          0);
        check("rst_rd_data",   rd_data,     0);
        check("rst_flags",     {mul_start, rd_valid, busy, err}, 0);
        check("rst_ready",     issue_ready, 1);

        // Multiply with product after 33 cycles; MFLO stalls behind it.
        ctl = MULTU; issue_valid = 1'b1;
        #1 check("multu_ready", issue_ready, 1);
        step();
        check("multu_start",   mul_start, 1);
        check("multu_busy",    busy,      1);
        ctl = MFLO;
        step();
        check("start_pulse",   mul_start, 0);
        ok = 1'b1;
        for (int i = 0; i < 31; i++) begin
            if (issue_ready !== 1'b0 || busy !== 1'b1 || mul_start !== 1'b0) ok = 1'b0;
            step();
        end
        check("stall_window",  ok, 1);
        prod_valid = 1'b1; prod = 64'h0000_0001_FFFF_FFFE;
        #1 check("stall_on_capture", issue_ready, 0);
        step();
        prod_valid = 1'b0;
        check("cap_hi",        hi,   32'h0000_0001);
        check("cap_lo",        lo,   32'hFFFF_FFFE);
        check("cap_idle",      busy, 0);
        check("mflo_ready",    issue_ready, 1);
        check("mflo_no_early", rd_valid, 0);
        step();
        issue_valid = 1'b0;
        check("mflo_valid",    rd_valid, 1);
        check("mflo_data",     rd_data,  32'hFFFF_FFFE);
        step();
        check("mflo_pulse",    rd_valid, 0);

        // MTHI then MFHI back to back, then MTLO/MFLO.
        ctl = MTHI; wr_data = 32'hDEAD_BEEF; issue_valid = 1'b1;
        step();
        check("mthi_hi",       hi, 32'hDEAD_BEEF);
        check("mthi_lo_keep",  lo, 32'hFFFF_FFFE);
        ctl = MFHI;
        step();
        issue_valid = 1'b0;
        check("mfhi_valid",    rd_valid, 1);
        check("mfhi_data",     rd_data,  32'hDEAD_BEEF);
        ctl = MTLO; wr_data = 32'h0BAD_F00D; issue_valid = 1'b1;
        step();
        check("mfhi_pulse",    rd_valid, 0);
        check("mtlo_lo",       lo, 32'h0BAD_F00D);
        check("mtlo_hi_keep",  hi, 32'hDEAD_BEEF);

        // Watchdog: no product ever arrives.
        ctl = MULTU;
        step();
        check("wd_start",      mul_start, 1);
        ctl = 6'd5;
        #1 check("unknown_ready_busy", issue_ready, 1);
        ok = 1'b1;
        for (int k = 1; k < TIMEOUT; k++) begin
            if (err !== 1'b0 || busy !== 1'b1) ok = 1'b0;
            step();
        end
        check("wd_waiting",    ok, 1);
        issue_valid = 1'b0;
        step();
        check("wd_err",        err,  1);
        check("wd_idle",       busy, 0);
        check("wd_hi_keep",    hi,   32'hDEAD_BEEF);
        check("wd_lo_keep",    lo,   32'h0BAD_F00D);
        prod_valid = 1'b1; prod = 64'hAAAA_AAAA_5555_5555;
        step();
        prod_valid = 1'b0;
        check("late_prod_hi",  hi,   32'hDEAD_BEEF);
        check("late_prod_lo",  lo,   32'h0BAD_F00D);
        check("err_sticky",    err,  1);

        // MULTU held across a capture is accepted on the first IDLE cycle.
        ctl = MULTU; issue_valid = 1'b1;
        step();
        step(); step(); step();
        prod_valid = 1'b1; prod = 64'h1111_2222_3333_4444;
        step();
        prod_valid = 1'b0;
        check("b2b_cap_hi",    hi,          32'h1111_2222);
        check("b2b_cap_lo",    lo,          32'h3333_4444);
        check("b2b_ready",     issue_ready, 1);
        check("b2b_no_start",  mul_start,   0);
        step();
        issue_valid = 1'b0;
        check("b2b_start",     mul_start, 1);
        check("b2b_busy",      busy,      1);

        // Reset ten cycles into that multiply, then a stale product.
        for (int i = 0; i < 9; i++) step();
        check("pre_rst_busy",  busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_hi",    hi, 0);
        check("mid_rst_lo",    lo, 0);
        check("mid_rst_flags", {mul_start, rd_valid, busy, err}, 0);
        check("mid_rst_rd",    rd_data, 0);
        step();
        rst = 1'b0;
        prod_valid = 1'b1; prod = 64'h9999_8888_7777_6666;
        step();
        prod_valid = 1'b0;
        check("post_rst_hi",   hi,   0);
        check("post_rst_lo",   lo,   0);
        check("post_rst_busy", busy, 0);

        // Product in IDLE is ignored.
        ctl = MTHI; wr_data = 32'hCAFE_0001; issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        prod_valid = 1'b1; prod = 64'h1234;
        step();
        prod_valid = 1'b0;
        check("idle_prod_hi",  hi, 32'hCAFE_0001);
        check("idle_prod_lo",  lo, 0);
        check("idle_prod_flags", {rd_valid, err, busy}, 0);

        // ctl is ignored when issue_valid is low.
        ctl = MULTU;
        step();
        check("no_valid_start", {mul_start, busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
